// File: rtl/mult_ctrl.sv
// -----------------------------------------------------------------------------
// mult_ctrl
// Control unit for a repeated-addition multiplier datapath (P register,
// Q down-counter, F accumulator, adder, zero comparator). It captures P and Q
// from the shared 4-bit input bus. It then repeats F <= F + P, decrementing Q
// each time, until the datapath reports Q == 0. Completion is reported to the
// host through a start/done/ack handshake. An abort request clears F and
// returns the unit to IDLE.
//
// Ports
//   clk_in      : clock, all state updates on the rising edge
//   rst_in      : synchronous active-high reset
//   start_i     : host request to begin a multiply, sampled only in IDLE
//   ack_i       : host acknowledges the result (ACK_MODE = 1)
//   abort_i     : cancel the operation in progress
//   zero_val_i  : datapath flag, Q counter == 0
//   load_p_o    : load P register from in_data
//   load_q_o    : load Q counter from in_data
//   load_f_o    : load F register with adder sum
//   clr_f_o     : clear F register
//   dec_q_o     : decrement Q counter
//   p_req_o     : host must drive P on in_data this cycle
//   q_req_o     : host must drive Q on in_data this cycle
//   busy_o      : high in every state except IDLE and DONE
//   done_o      : result valid on datapath out_data
//   iter_cnt_o  : accumulate steps in the current or last operation
// -----------------------------------------------------------------------------
module mult_ctrl #(
   parameter int CNT_W    = 4,
   parameter int ACK_MODE = 1
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic             start_i,
   input  logic             ack_i,
   input  logic             abort_i,
   input  logic             zero_val_i,
   output logic             load_p_o,
   output logic             load_q_o,
   output logic             load_f_o,
   output logic             clr_f_o,
   output logic             dec_q_o,
   output logic             p_req_o,
   output logic             q_req_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] iter_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_P,
      S_LOAD_Q,
      S_CHECK,
      S_ACC,
      S_DONE,
      S_CLEAR
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_iter;
   logic             r_load_p, r_load_q, r_load_f, r_clr_f, r_dec_q;
   logic             r_p_req, r_q_req, r_busy, r_done;
   logic             w_abort;

   // Abort only matters while an operation or its result is live.
   assign w_abort = abort_i && (r_state inside {S_LOAD_P, S_LOAD_Q, S_CHECK, S_ACC, S_DONE});

   // NOTE: w_next is given a default before the case so that no path leaves it
   // unassigned; otherwise synthesis infers a latch.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   if (start_i) w_next = S_LOAD_P;
         S_LOAD_P: w_next = S_LOAD_Q;
         S_LOAD_Q: w_next = S_CHECK;
         // Q has had a full cycle to settle since its last load or decrement.
         S_CHECK:  w_next = zero_val_i ? S_DONE : S_ACC;
         S_ACC:    w_next = S_CHECK;
         S_DONE:   if ((ACK_MODE == 0) || ack_i) w_next = S_IDLE;
         S_CLEAR:  w_next = S_IDLE;
         default:  w_next = S_IDLE;
      endcase
      if (w_abort) w_next = S_CLEAR;
   end

   // Outputs are registered from the next state, so each one is a pure
   // function of the registered state and cannot glitch.
   // NOTE: every register here uses non-blocking assignment so that all of
   // them update together from values sampled before the edge.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state  <= S_IDLE;
         r_iter   <= '0;
         r_load_p <= 1'b0;
         r_load_q <= 1'b0;
         r_load_f <= 1'b0;
         r_clr_f  <= 1'b0;
         r_dec_q  <= 1'b0;
         r_p_req  <= 1'b0;
         r_q_req  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_load_p <= (w_next == S_LOAD_P);
         r_p_req  <= (w_next == S_LOAD_P);
         r_load_q <= (w_next == S_LOAD_Q);
         r_q_req  <= (w_next == S_LOAD_Q);
         r_clr_f  <= (w_next == S_LOAD_Q) || (w_next == S_CLEAR);
         r_load_f <= (w_next == S_ACC);
         r_dec_q  <= (w_next == S_ACC);
         r_done   <= (w_next == S_DONE);
         r_busy   <= !(w_next inside {S_IDLE, S_DONE});

         // The count is kept through DONE and IDLE so the host can read it
         // after the handshake completes.
         if (r_state == S_LOAD_Q) begin
            r_iter <= '0;
         end else if ((r_state == S_ACC) && (r_iter != CNT_MAX)) begin
            r_iter <= r_iter + 1'b1;
         end
      end
   end

   assign load_p_o   = r_load_p;
   assign load_q_o   = r_load_q;
   assign load_f_o   = r_load_f;
   assign clr_f_o    = r_clr_f;
   assign dec_q_o    = r_dec_q;
   assign p_req_o    = r_p_req;
   assign q_req_o    = r_q_req;
   assign busy_o     = r_busy;
   assign done_o     = r_done;
   assign iter_cnt_o = r_iter;

endmodule

// File: tb/tb_mult_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_ctrl
// Directed bench for mult_ctrl. Two controllers are instantiated: index 0 uses
// ACK_MODE=1 and index 1 uses ACK_MODE=0. Each controller drives a behavioural
// datapath (P, Q, F, zero flag) and a host bus responder. Expected product,
// iteration count and latency are pushed to a scoreboard when a start is
// issued. They are popped and compared when done_o rises.
// -----------------------------------------------------------------------------
module tb_mult_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] start_s, ack_s, abort_s, zero_s;
   logic [1:0] load_p_s, load_q_s, load_f_s, clr_f_s, dec_q_s;
   logic [1:0] p_req_s, q_req_s, busy_s, done_s;
   logic [3:0] iter_s [2];

   logic [3:0] op_p [2];
   logic [3:0] op_q [2];
   logic [3:0] bus  [2];
   logic [3:0] dp_p [2];
   logic [3:0] dp_q [2];
   logic [7:0] dp_f [2];

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] prod;
      logic [3:0] iter;
      int         lat;
   } exp_t;
   exp_t sb[$];

   mult_ctrl #(.CNT_W(4), .ACK_MODE(1)) u_dut0 (
      .clk_in(clk), .rst_in(rst), .start_i(start_s[0]), .ack_i(ack_s[0]),
      .abort_i(abort_s[0]), .zero_val_i(zero_s[0]), .load_p_o(load_p_s[0]),
      .load_q_o(load_q_s[0]), .load_f_o(load_f_s[0]), .clr_f_o(clr_f_s[0]),
      .dec_q_o(dec_q_s[0]), .p_req_o(p_req_s[0]), .q_req_o(q_req_s[0]),
      .busy_o(busy_s[0]), .done_o(done_s[0]), .iter_cnt_o(iter_s[0])
   );

   mult_ctrl #(.CNT_W(4), .ACK_MODE(0)) u_dut1 (
      .clk_in(clk), .rst_in(rst), .start_i(start_s[1]), .ack_i(ack_s[1]),
      .abort_i(abort_s[1]), .zero_val_i(zero_s[1]), .load_p_o(load_p_s[1]),
      .load_q_o(load_q_s[1]), .load_f_o(load_f_s[1]), .clr_f_o(clr_f_s[1]),
      .dec_q_o(dec_q_s[1]), .p_req_o(p_req_s[1]), .q_req_o(q_req_s[1]),
      .busy_o(busy_s[1]), .done_o(done_s[1]), .iter_cnt_o(iter_s[1])
   );

   // Host bus responder and datapath zero comparator.
   assign bus[0]    = p_req_s[0] ? op_p[0] : (q_req_s[0] ? op_q[0] : 4'h0);
   assign bus[1]    = p_req_s[1] ? op_p[1] : (q_req_s[1] ? op_q[1] : 4'h0);
   assign zero_s[0] = (dp_q[0] == 4'd0);
   assign zero_s[1] = (dp_q[1] == 4'd0);

   // Behavioural datapath.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (load_p_s[k]) dp_p[k] <= bus[k];
         if (load_q_s[k]) dp_q[k] <= bus[k];
         else if (dec_q_s[k]) dp_q[k] <= dp_q[k] - 4'd1;
         if (clr_f_s[k]) dp_f[k] <= 8'd0;
         else if (load_f_s[k]) dp_f[k] <= dp_f[k] + {4'd0, dp_p[k]};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_idle(input int k, input string tag);
      check(tag, {23'd0, load_p_s[k], load_q_s[k], load_f_s[k], clr_f_s[k], dec_q_s[k],
                  p_req_s[k], q_req_s[k], busy_s[k], done_s[k]}, 32'd0);
   endtask

   // Start one multiply and follow it until done_o rises or the budget expires.
   task automatic run_op(input int k, input logic [3:0] p, input logic [3:0] q,
                         input bit dup_start);
      exp_t e;
      int   lat, nacc, ndec;
      bit   seen;
      op_p[k] = p;
      op_q[k] = q;
      e.prod  = 8'(p) * 8'(q);
      e.iter  = q;
      e.lat   = 2 * int'(q) + 4;
      sb.push_back(e);
      start_s[k] = 1'b1;
      tick();
      start_s[k] = 1'b0;
      lat  = 1;
      nacc = 0;
      ndec = 0;
      seen = 1'b0;
      while (lat <= 40) begin
         if (lat == 1) check("load_p_cycle", {29'd0, load_p_s[k], p_req_s[k], busy_s[k]}, 32'd7);
         if (lat == 2) check("load_q_cycle", {29'd0, load_q_s[k], q_req_s[k], clr_f_s[k]}, 32'd7);
         if (done_s[k]) begin
            seen = 1'b1;
            break;
         end
         nacc += int'(load_f_s[k]);
         ndec += int'(dec_q_s[k]);
         if (dup_start) start_s[k] = (lat == 3);
         tick();
         lat++;
      end
      start_s[k] = 1'b0;
      e = sb.pop_front();
      check("done_seen", {31'd0, seen}, 32'd1);
      check("done_latency", lat, e.lat);
      check("out_data", {24'd0, dp_f[k]}, {24'd0, e.prod});
      check("iter_cnt", {28'd0, iter_s[k]}, {28'd0, e.iter});
      check("acc_pulses", nacc, int'(e.iter));
      check("dec_pulses", ndec, int'(e.iter));
      check("busy_in_done", {31'd0, busy_s[k]}, 32'd0);
   endtask

   initial begin
      int nacc;
      rst     = 1'b1;
      start_s = '0;
      ack_s   = '0;
      abort_s = '0;
      op_p[0] = 4'd0; op_p[1] = 4'd0;
      op_q[0] = 4'd0; op_q[1] = 4'd0;
      tick();
      tick();
      check_idle(0, "reset_outputs0");
      check_idle(1, "reset_outputs1");
      check("reset_iter0", {28'd0, iter_s[0]}, 32'd0);
      check("reset_iter1", {28'd0, iter_s[1]}, 32'd0);
      rst = 1'b0;
      tick();

      // 1: P=5, Q=3 with handshake.
      run_op(0, 4'd5, 4'd3, 1'b0);
      tick();
      check("done_held", {31'd0, done_s[0]}, 32'd1);
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      check_idle(0, "idle_after_ack");
      check("f_held_idle", {24'd0, dp_f[0]}, 32'd15);
      check("iter_held_idle", {28'd0, iter_s[0]}, 32'd3);

      // 2: Q=0 finishes with no accumulate steps.
      run_op(0, 4'd9, 4'd0, 1'b0);
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      check_idle(0, "idle_after_q0");

      // 3: largest operands, with a start issued while busy.
      run_op(0, 4'd15, 4'd15, 1'b1);
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      check_idle(0, "idle_after_15x15");
      tick();
      check_idle(0, "start_not_queued");

      // 4a: abort in the second ACC cycle of P=4, Q=6.
      op_p[0] = 4'd4;
      op_q[0] = 4'd6;
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      nacc = 0;
      for (int i = 0; i < 20; i++) begin
         nacc += int'(load_f_s[0]);
         if (nacc == 2) break;
         tick();
      end
      check("second_acc_reached", nacc, 2);
      abort_s[0] = 1'b1;
      tick();
      abort_s[0] = 1'b0;
      check("abort_clear", {28'd0, clr_f_s[0], busy_s[0], load_f_s[0], done_s[0]}, 32'b1100);
      tick();
      check_idle(0, "idle_after_abort");
      check("f_after_abort", {24'd0, dp_f[0]}, 32'd0);

      // 4b: abort in IDLE is ignored.
      abort_s[0] = 1'b1;
      tick();
      abort_s[0] = 1'b0;
      check_idle(0, "abort_in_idle");

      // 4c: abort together with ack in DONE goes to CLEAR.
      run_op(0, 4'd1, 4'd1, 1'b0);
      abort_s[0] = 1'b1;
      ack_s[0]   = 1'b1;
      tick();
      abort_s[0] = 1'b0;
      ack_s[0]   = 1'b0;
      check("abort_beats_ack", {30'd0, clr_f_s[0], done_s[0]}, 32'b10);
      tick();
      check_idle(0, "idle_after_abort_ack");

      // 5: reset asserted in CHECK.
      op_p[0] = 4'd7;
      op_q[0] = 4'd5;
      start_s[0] = 1'b1;
      tick();
      start_s[0] = 1'b0;
      tick();
      tick();
      check("in_check", {23'd0, load_p_s[0], load_q_s[0], load_f_s[0], clr_f_s[0], dec_q_s[0],
                         p_req_s[0], q_req_s[0], busy_s[0], done_s[0]}, 32'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle(0, "reset_mid_op");
      check("reset_mid_iter", {28'd0, iter_s[0]}, 32'd0);
      tick();
      check_idle(0, "no_strobe_after_reset");
      run_op(0, 4'd2, 4'd2, 1'b0);
      ack_s[0] = 1'b1;
      tick();
      ack_s[0] = 1'b0;
      check_idle(0, "idle_after_2x2");

      // 6: pulse-mode controller, P=3, Q=1.
      run_op(1, 4'd3, 4'd1, 1'b0);
      tick();
      check_idle(1, "pulse_done_one_cycle");
      check("pulse_f_held", {24'd0, dp_f[1]}, 32'd3);
      tick();
      check_idle(1, "pulse_stays_idle");
      check("pulse_f_still_held", {24'd0, dp_f[1]}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
